rs232_tx_packet: RTL
====================

# rs232_tx_packet

Transmit-side framer and UART serializer for the RS-232 link. It sits directly downstream of the packet receiver and its 128x32 RAM. On a read request it captures the 32-bit RAM word and serializes a fixed 8-byte response packet on the `tx` line. The packet byte layout and bit timing mirror the receive path, so the host sees the same frame format in both directions.

## Interface
- `CLKS_PER_BIT`, default 47: clk cycles per serial bit (start, data and stop bits alike); legal range 2..8191.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_start`  in  1  one-cycle request pulse from the receiver; `ram_out` is valid in the same cycle.
- `ram_out`  in  32  RAM read data; captured only on an accepted `tx_start`.
- `tx`  out  1  serial line; idle level 1; registered output.
- `busy`  out  1  high from the cycle after acceptance until the packet completes.
- `done`  out  1  one-cycle pulse when the last stop bit ends.
- `overrun`  out  1  one-cycle pulse when `tx_start` arrives while `busy`=1.

## Operation
- Packet bytes, in send order:
  - B0 = 0x02
  - B1 = 0x00 (response flag)
  - B2 = D[7:0]
  - B3 = D[15:8]
  - B4 = D[23:16]
  - B5 = D[31:24]
  - B6 = B2^B3^B4^B5 (XOR checksum)
  - B7 = 0x03
- Byte framing: start bit 0, then 8 data bits LSB first, then 1 stop bit 1. Each byte is 10 bit-times. There is no idle gap between bytes.
- FSM states: IDLE, LOAD, START, DATA, STOP, DONE.
  - IDLE: `tx`=1, `busy`=0. On `tx_start`=1, capture `ram_out` into `D` and go to LOAD.
  - LOAD: select byte `B[byte_idx]` into an 8-bit shift register, clear the bit counter and baud counter, then go to START. This state is zero-width on the line; see Timing.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift[0]; shift right every `CLKS_PER_BIT` cycles. After 8 bits, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then, if `byte_idx`=7, go to DONE; otherwise increment `byte_idx` and go to LOAD.
  - DONE: `done`=1 for one cycle, `byte_idx` cleared, then go to IDLE.
- Counters:
  - Baud counter: 13 bits, counts 0..`CLKS_PER_BIT`-1, with a bit-tick at terminal count.
  - Bit counter: 0..7.
  - `byte_idx`: 0..7, 3 bits, wraps to 0 only via DONE.
- Checksum is computed combinationally from the captured `D`. It is not accumulated serially.
- Boundary conditions:
  - `tx_start` while `busy`: the request is dropped, `D` is unchanged, and `overrun` pulses for 1 cycle.
  - `tx_start` in the DONE cycle: counts as busy and is dropped with `overrun`.
  - `tx_start` in the first IDLE cycle after DONE: accepted normally.
  - `ram_out` changing after capture has no effect on the packet in flight.
  - `rst` mid-packet: at the next edge the FSM is in IDLE and `tx`=1. The packet is truncated with no stop-bit completion. No `done` and no `overrun` are generated.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `overrun`=0, state IDLE, `byte_idx`=0, `D`=0.
- Acceptance of `tx_start` at edge k:
  - `busy`=1 and the state is LOAD after edge k.
  - `tx` falls to 0 after edge k+1, because LOAD costs one cycle before START.
- Each bit is held on `tx` for exactly `CLKS_PER_BIT` cycles.
- LOAD for bytes 1..7 overlaps the final cycle of the previous stop bit, so the stop bit is not stretched. The next start bit follows the previous stop bit with no gap. Inter-byte spacing is exactly 10×`CLKS_PER_BIT`.
- Total line time from the first start-bit edge to the end of the last stop bit: 80×`CLKS_PER_BIT` cycles (3760 at default).
- `done`=1 in the cycle immediately after the last stop bit. `busy` falls in the same cycle `done` is asserted, and `tx` stays 1.
- `overrun` is asserted in the cycle after the offending `tx_start` edge.

## Test plan
- Reset then idle: hold `rst` for 3 cycles, then 200 idle cycles. Required: `tx`=1, `busy`=0, `done`=0 and `overrun`=0 throughout.
- Basic packet: `ram_out`=0x12345678, `tx_start` pulse, default parameter. A UART monitor decodes 02 00 78 56 34 12 08 03. `done` pulses exactly 3760 cycles after the first `tx` falling edge, plus the stop-bit end, per Timing.
- Bit timing: `CLKS_PER_BIT`=4, `ram_out`=0xFFFFFFFF. Required:
  - Every bit lasts exactly 4 cycles.
  - Bytes are 02 00 FF FF FF FF 00 03.
  - Total line time is 320 cycles.
- Overrun and capture stability: start a packet with 0xA5A5A5A5. At bit-time 20, pulse `tx_start` with `ram_out`=0x00000000. Required: one `overrun` pulse, and the packet stays 02 00 A5 A5 A5 A5 00 03.
- Reset mid-packet: assert `rst` during byte B3 data. Required: `tx`=1 and `busy`=0 after the next edge, with no `done`. A new `tx_start` with 0x01020304 then yields 02 00 04 03 02 01 04 03.
- Back-to-back: issue a second `tx_start` in the first IDLE cycle after `done`. Required: it is accepted with no `overrun`, and the second packet's start bit follows 1 LOAD cycle later.

Source files
------------

// File: rtl/rs232_tx_packet.sv
`default_nettype none
// ============================================================================
// Module      : rs232_tx_packet
// Description : Captures a 32-bit RAM word and serializes a fixed 8-byte
//               response packet (8N1 UART framing) on the tx line.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_tx_packet #(
    parameter int CLKS_PER_BIT = 47
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [31:0] ram_out,
    output logic        tx,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [12:0] c_BAUD_LAST    = 13'(CLKS_PER_BIT - 1);
    localparam logic [12:0] c_BAUD_HANDOFF = 13'(CLKS_PER_BIT - 2);

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  shift_q, shift_d;
    logic [12:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  byte_q, byte_d;
    logic        tx_q, busy_q, done_q, overrun_q;
    logic        tx_d;
    logic [7:0]  cur_byte;
    logic [7:0]  checksum;
    logic        baud_tick;

    assign checksum  = data_q[7:0] ^ data_q[15:8] ^ data_q[23:16] ^ data_q[31:24];
    assign baud_tick = (baud_q == c_BAUD_LAST);

    always_comb begin
        cur_byte = 8'h00;
        case (byte_q)
            3'd0:    cur_byte = 8'h02;
            3'd1:    cur_byte = 8'h00;
            3'd2:    cur_byte = data_q[7:0];
            3'd3:    cur_byte = data_q[15:8];
            3'd4:    cur_byte = data_q[23:16];
            3'd5:    cur_byte = data_q[31:24];
            3'd6:    cur_byte = checksum;
            default: cur_byte = 8'h03;
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        case (state_q)
            S_IDLE: begin
                byte_d = 3'd0;
                if (tx_start) begin
                    data_d  = ram_out;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shift_d = cur_byte;
                bit_d   = 3'd0;
                baud_d  = 13'd0;
                state_d = S_START;
            end
            S_START: begin
                if (baud_tick) begin
                    baud_d  = 13'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 13'd1;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    baud_d = 13'd0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 13'd1;
                end
            end
            S_STOP: begin
                // Hand off one cycle early so LOAD occupies the final stop cycle.
                if (byte_q != 3'd7 && baud_q == c_BAUD_HANDOFF) begin
                    byte_d  = byte_q + 3'd1;
                    state_d = S_LOAD;
                end else if (byte_q == 3'd7 && baud_tick) begin
                    state_d = S_DONE;
                end else begin
                    baud_d = baud_q + 13'd1;
                end
            end
            S_DONE: begin
                byte_d  = 3'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data_q    <= 32'd0;
            shift_q   <= 8'd0;
            baud_q    <= 13'd0;
            bit_q     <= 3'd0;
            byte_q    <= 3'd0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            busy_q    <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_q    <= (state_d == S_DONE);
            overrun_q <= tx_start && (state_q != S_IDLE);
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule
`default_nettype wire
